// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: synchronizes the serial line, frames start/data/stop bits
// and presents each byte through a valid/ready output register.
module uart_rx_framer #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       FrameError,
    output logic       Overrun
);

    localparam int BitPeriod  = ClockFreq / BaudRate;
    localparam int HalfPeriod = BitPeriod / 2;
    localparam int CntW       = $clog2(BitPeriod);

    localparam logic [CntW-1:0] BitLast  = CntW'(BitPeriod - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfPeriod - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_e;

    rxState_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync2_q;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frameErr_q, frameErr_d;
    logic            overrun_q, overrun_d;

    logic            rxBit;
    logic            byteDone;
    logic            stopBad;
    logic            handshake;

    // Synchronizer flops idle high so reset never looks like a start bit.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= SIn;
            sync2_q <= sync1_q;
        end
    end

    assign rxBit = sync2_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
        end
    end

    // Start bit is re-checked at mid-bit; data and stop are sampled one full period later each.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        byteDone = 1'b0;
        stopBad  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bitIdx_d = '0;
                if (!rxBit) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    state_d = rxBit ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d    = '0;
                    shift_d  = {rxBit, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BitLast) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    byteDone = rxBit;
                    stopBad  = !rxBit;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign handshake = valid_q & DataOutReady;

    // A completed byte loads only into a free (or simultaneously drained) register.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        frameErr_d = stopBad;
        overrun_d  = 1'b0;
        if (byteDone && (!valid_q || handshake)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else begin
            if (handshake) begin
                valid_d = 1'b0;
            end
            overrun_d = byteDone & valid_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign DataOut      = data_q;
    assign DataOutValid = valid_q;
    assign FrameError   = frameErr_q;
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at T=8, H=4: framing, handshake,
// frame error, overrun, glitch rejection and mid-frame reset.
module tb_uart_rx_framer;

    localparam int ClockFreq = 800;
    localparam int BaudRate  = 100;
    localparam int BitCycles = 8;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       sIn = 1'b1;
    logic       dataOutReady = 1'b0;
    logic [7:0] dataOut;
    logic       dataOutValid;
    logic       frameError;
    logic       overrun;

    int         compared = 0;
    int         mismatched = 0;
    int         feCount = 0;
    int         ovCount = 0;
    int         fe0;
    int         ov0;
    logic [7:0] hsQ[$];

    uart_rx_framer #(
        .ClockFreq(ClockFreq),
        .BaudRate (BaudRate)
    ) dut (
        .Clock       (clock),
        .Reset       (resetN),
        .SIn         (sIn),
        .DataOut     (dataOut),
        .DataOutValid(dataOutValid),
        .DataOutReady(dataOutReady),
        .FrameError  (frameError),
        .Overrun     (overrun)
    );

    always #5 clock = ~clock;

    // Pulse counters and accepted-byte log, sampled mid-cycle.
    always @(negedge clock) begin
        if (frameError) feCount++;
        if (overrun) ovCount++;
        if (dataOutValid && dataOutReady) hsQ.push_back(dataOut);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] hsAt(input int i);
        if (i < hsQ.size()) return {24'h0, hsQ[i]};
        return 32'hDEAD;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // One 8N1 frame, LSB first, each bit held for one bit period.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        sIn = 1'b0;
        tick(BitCycles);
        for (int i = 0; i < 8; i++) begin
            sIn = b[i];
            tick(BitCycles);
        end
        sIn = stopBit;
        tick(BitCycles);
    endtask

    initial begin
        #23;
        checkOutput("rst_data", dataOut, 8'h00);
        checkOutput("rst_valid", dataOutValid, 1'b0);
        checkOutput("rst_fe", frameError, 1'b0);
        checkOutput("rst_ovr", overrun, 1'b0);
        #4;
        resetN = 1'b1;
        @(posedge clock);
        #2;
        tick(4);

        $display("[TB] frame 0xAA, ready low");
        hsQ.delete();
        applyStimulus(8'hAA, 1'b1);
        checkOutput("aa_valid", dataOutValid, 1'b1);
        checkOutput("aa_data", dataOut, 8'hAA);
        tick(5);
        checkOutput("aa_hold_valid", dataOutValid, 1'b1);
        checkOutput("aa_hold_data", dataOut, 8'hAA);
        dataOutReady = 1'b1;
        tick(1);
        dataOutReady = 1'b0;
        checkOutput("aa_drop_valid", dataOutValid, 1'b0);
        checkOutput("aa_hs_count", hsQ.size(), 1);
        checkOutput("aa_hs_data", hsAt(0), 8'hAA);

        $display("[TB] back-to-back 0x55, 0x0F, ready high");
        fe0 = feCount;
        ov0 = ovCount;
        hsQ.delete();
        dataOutReady = 1'b1;
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h0F, 1'b1);
        tick(4);
        dataOutReady = 1'b0;
        checkOutput("b2b_hs_count", hsQ.size(), 2);
        checkOutput("b2b_first", hsAt(0), 8'h55);
        checkOutput("b2b_second", hsAt(1), 8'h0F);
        checkOutput("b2b_fe", feCount - fe0, 0);
        checkOutput("b2b_ovr", ovCount - ov0, 0);
        checkOutput("b2b_valid", dataOutValid, 1'b0);

        $display("[TB] frame 0x3C with bad stop, then 0x81");
        tick(4);
        fe0 = feCount;
        ov0 = ovCount;
        applyStimulus(8'h3C, 1'b0);
        sIn = 1'b1;
        tick(2);
        checkOutput("ferr_pulse", feCount - fe0, 1);
        checkOutput("ferr_valid", dataOutValid, 1'b0);
        checkOutput("ferr_ovr", ovCount - ov0, 0);
        tick(16);
        applyStimulus(8'h81, 1'b1);
        tick(1);
        checkOutput("after_ferr_data", dataOut, 8'h81);
        checkOutput("after_ferr_valid", dataOutValid, 1'b1);
        checkOutput("after_ferr_fe", feCount - fe0, 1);
        dataOutReady = 1'b1;
        tick(1);
        dataOutReady = 1'b0;
        checkOutput("after_ferr_clear", dataOutValid, 1'b0);

        $display("[TB] overrun 0x11 then 0x22, ready low");
        tick(4);
        ov0 = ovCount;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        tick(2);
        checkOutput("ovr_data_kept", dataOut, 8'h11);
        checkOutput("ovr_valid", dataOutValid, 1'b1);
        checkOutput("ovr_once", ovCount - ov0, 1);

        $display("[TB] 0x22 completes in the handshake cycle");
        ov0 = ovCount;
        hsQ.delete();
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                tick(78);
                dataOutReady = 1'b1;
                tick(1);
                dataOutReady = 1'b0;
            end
        join
        tick(1);
        checkOutput("same_cycle_data", dataOut, 8'h22);
        checkOutput("same_cycle_valid", dataOutValid, 1'b1);
        checkOutput("same_cycle_ovr", ovCount - ov0, 0);
        checkOutput("same_cycle_hs", hsAt(0), 8'h11);
        dataOutReady = 1'b1;
        tick(1);
        dataOutReady = 1'b0;
        checkOutput("same_cycle_clear", dataOutValid, 1'b0);

        $display("[TB] two-cycle glitch");
        tick(4);
        fe0 = feCount;
        ov0 = ovCount;
        sIn = 1'b0;
        tick(2);
        sIn = 1'b1;
        tick(40);
        checkOutput("glitch_valid", dataOutValid, 1'b0);
        checkOutput("glitch_fe", feCount - fe0, 0);
        checkOutput("glitch_ovr", ovCount - ov0, 0);

        $display("[TB] reset during data bit 4 of 0xFF");
        applyStimulus(8'h33, 1'b1);
        tick(2);
        checkOutput("pre_rst_data", dataOut, 8'h33);
        fe0 = feCount;
        ov0 = ovCount;
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                tick(44);
                #2;
                resetN = 1'b0;
                #1;
                checkOutput("midrst_data", dataOut, 8'h00);
                checkOutput("midrst_valid", dataOutValid, 1'b0);
                checkOutput("midrst_fe", frameError, 1'b0);
                checkOutput("midrst_ovr", overrun, 1'b0);
                repeat (3) @(posedge clock);
                #4;
                resetN = 1'b1;
            end
        join
        tick(2);
        checkOutput("abandon_valid", dataOutValid, 1'b0);
        checkOutput("abandon_fe", feCount - fe0, 0);
        checkOutput("abandon_ovr", ovCount - ov0, 0);
        applyStimulus(8'h5A, 1'b1);
        tick(2);
        checkOutput("post_rst_data", dataOut, 8'h5A);
        checkOutput("post_rst_valid", dataOutValid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
- REQ-001: The block SHALL have parameter `ClockFreq`, default 50_000_000: Clock frequency in Hz.
- REQ-002: The block SHALL have parameter `BaudRate`, default 115_200: serial bit rate.
- REQ-003: The block SHALL have port `Clock`, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004: The block SHALL have port `Reset`, input, 1 bit: reset, asynchronous and active-low.
- REQ-005: The block SHALL have port `SIn`, input, 1 bit: asynchronous serial line, idle high, fed from the FPGA pin.
- REQ-006: The block SHALL have port `DataOut`, output, 8 bits: received byte, consumed by IOInterface through its receive-data register at 0x80000004.
- REQ-007: The block SHALL have port `DataOutValid`, output, 1 bit: `DataOut` holds an unconsumed byte; drives IOInterface control bit 1 at 0x80000000.
- REQ-008: The block SHALL have port `DataOutReady`, input, 1 bit: consumer accepts the byte this cycle.
- REQ-009: The block SHALL have port `FrameError`, output, 1 bit: one-cycle pulse when a bad stop bit is detected.
- REQ-010: The block SHALL have port `Overrun`, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
- REQ-011: The block SHALL define bit period T = ClockFreq/BaudRate (integer division) and half period H = T/2; T < 4 is unsupported; counter width SHALL be $clog2(T).
- REQ-012: `SIn` SHALL pass through a 2-flop synchronizer whose flops reset to 1; all FSM decisions SHALL use the synchronized value only.
- REQ-013: The FSM SHALL have states IDLE, START, DATA, STOP.
- REQ-014: In IDLE, synchronized `SIn`=0 SHALL move the FSM to START with the bit counter cleared.
- REQ-015: In START, at count H-1, synchronized `SIn`=0 SHALL move the FSM to DATA with the counter cleared; `SIn`=1 is a glitch and SHALL return the FSM to IDLE with no output and no error.
- REQ-016: In DATA, the block SHALL sample at each count T-1, shift LSB first into an 8-bit shift register, and after the 8th sample move to STOP with the counter cleared.
- REQ-017: In STOP, at count T-1 with `SIn`=1, the byte is complete; with `SIn`=0, `FrameError` SHALL pulse for exactly one cycle and the byte SHALL be discarded.
- REQ-018: After either STOP outcome the FSM SHALL enter IDLE on the next cycle, so back-to-back frames with a single stop bit are received.
- REQ-019: On byte complete, with `DataOutValid`=0, the output register SHALL load the byte and `DataOutValid` SHALL rise on the next Clock edge.
- REQ-020: Handshake: `DataOutValid` SHALL remain high and `DataOut` SHALL remain stable until a cycle with `DataOutValid`&`DataOutReady`=1, after which `DataOutValid` SHALL drop.
- REQ-021: When byte complete and handshake occur in the same cycle, the new byte SHALL load and `DataOutValid` SHALL stay 1; `Overrun` SHALL stay 0.
- REQ-022: When byte complete occurs with `DataOutValid`=1 and no handshake, the old byte SHALL be kept, the new byte dropped, and `Overrun` SHALL pulse for one cycle.
- REQ-023: `DataOutReady` while `DataOutValid`=0 SHALL have no effect.
- REQ-024: Latency SHALL be `DataOutValid` high within 2+H+9T+2 cycles of the first Clock edge that samples raw `SIn`=0.
- REQ-025: `FrameError` and `Overrun` SHALL never pulse in the same cycle as each other for different frames; each frame SHALL produce at most one of: load, `FrameError`, `Overrun`.

Reset
- REQ-026: `Reset`=0 SHALL asynchronously force: FSM to IDLE, counters to 0, synchronizer flops to 1, `DataOut`=8'h00, `DataOutValid`=0, `FrameError`=0, `Overrun`=0.
- REQ-027: Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a new falling edge, and a line already low at release SHALL be treated as a start bit.
- REQ-028: Reset release SHALL be usable at any edge; outputs SHALL first change on the first Clock edge after release.

Verification
- REQ-029: Use ClockFreq=800 and BaudRate=100 (T=8, H=4) for all scenarios below.
- REQ-030: Frame 0xAA (start, 0,1,0,1,0,1,0,1, stop=1) with `DataOutReady`=0 -> `DataOut`=8'hAA, `DataOutValid`=1 by cycle 80, held until `DataOutReady`=1 for one cycle, then 0.
- REQ-031: Frames 0x55 and 0x0F back-to-back with `DataOutReady` tied 1 -> two handshakes with 8'h55 then 8'h0F, no `Overrun`/`FrameError`.
- REQ-032: Frame 0x3C with stop bit 0 -> `FrameError` one-cycle pulse, `DataOutValid` stays 0, next good frame 0x81 received correctly.
- REQ-033: Frames 0x11 then 0x22 with `DataOutReady`=0 throughout -> `DataOut`=8'h11 retained, `Overrun` pulses once at second stop; then `DataOutReady`=1 at the exact second-complete cycle -> 0x22 loaded, no `Overrun`.
- REQ-034: 2-cycle low glitch on `SIn` -> no output, no error; `Reset`=0 during DATA bit 4 of 0xFF -> all outputs 0 immediately, following frame 0x5A received as 8'h5A.
